// File: rtl/uart_rx_fifo.sv
// UART receiver for the host command link: synchronised, 3-sample voted bits, configurable
// framing, and a show-ahead receive FIFO carrying per-byte parity/frame error flags.
module uart_rx_fifo #(
   parameter int CLK_FREQ    = 40_000_000,
   parameter int BAUD_RATE   = 1_000_000,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic                        rx_i,
   input  logic                        data_ack_i,
   input  logic                        err_clr_i,
   output logic [7:0]                  data_o,
   output logic                        data_valid_o,
   output logic                        parity_err_o,
   output logic                        frame_err_o,
   output logic                        overflow_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);
   localparam int CPB = CLK_FREQ / BAUD_RATE;
   localparam int CW  = $clog2(CPB);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] C_HALF = CW'(CPB / 2 - 1);
   localparam logic [CW-1:0] C_S1   = CW'(CPB - 3);
   localparam logic [CW-1:0] C_S2   = CW'(CPB - 2);
   localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT} state_t;

   typedef struct packed {
      logic       p_err;
      logic       f_err;
      logic [7:0] data;
   } entry_t;

   state_t          state_q, state_d;
   logic [1:0]      sync_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      sh_q, sh_d;
   logic            perr_q, perr_d, ferr_q, ferr_d;
   logic [1:0]      smp_q, smp_d;
   logic            rx_s, vote, bit_end, push;
   entry_t          push_ent;

   entry_t          mem_q [FIFO_DEPTH];
   logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
   logic [AW:0]     fcnt_q, fcnt_d;
   logic            ovf_q, ovf_d;
   logic            pop, full, wr_en, drop;
   entry_t          head;

   assign rx_s    = sync_q[1];
   assign bit_end = (cnt_q == C_LAST);
   // the third vote is the live sample taken at the bit centre
   assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      sh_d     = sh_q;
      perr_d   = perr_q;
      ferr_d   = ferr_q;
      smp_d    = smp_q;
      push     = 1'b0;
      if (cnt_q == C_S1) smp_d[0] = rx_s;
      if (cnt_q == C_S2) smp_d[1] = rx_s;
      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == C_HALF) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  bit_d   = '0;
                  sh_d    = '0;
                  perr_d  = 1'b0;
                  ferr_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d       = '0;
               sh_d[bit_q] = vote;
               if (bit_q == 3'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               perr_d  = (PARITY_MODE == 1) ? ~(^sh_q ^ vote) : (^sh_q ^ vote);
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (!vote) ferr_d = 1'b1;
               if (bit_q == 3'(STOP_BITS - 1)) begin
                  push    = 1'b1;
                  state_d = ferr_d ? S_WAIT : S_IDLE;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT: begin
            // a held-low line (break) yields a single entry, not a stream of them
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign push_ent = '{p_err: perr_q, f_err: ferr_d, data: sh_q};

   always_comb begin
      pop    = data_ack_i && (fcnt_q != '0);
      full   = (fcnt_q == FULL_CNT);
      wr_en  = push && (!full || pop);
      drop   = push && full && !pop;
      rd_d   = pop   ? rd_q + 1'b1 : rd_q;
      wr_d   = wr_en ? wr_q + 1'b1 : wr_q;
      fcnt_d = fcnt_q;
      if (wr_en && !pop)      fcnt_d = fcnt_q + 1'b1;
      else if (!wr_en && pop) fcnt_d = fcnt_q - 1'b1;
      ovf_d  = drop ? 1'b1 : (err_clr_i ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sync_q  <= 2'b11;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         smp_q   <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         fcnt_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], rx_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         smp_q   <= smp_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         fcnt_q  <= fcnt_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_n_i && wr_en) mem_q[wr_q] <= push_ent;
   end

   assign head         = mem_q[rd_q];
   assign data_valid_o = (fcnt_q != '0);
   assign data_o       = data_valid_o ? head.data  : 8'h00;
   assign parity_err_o = data_valid_o ? head.p_err : 1'b0;
   assign frame_err_o  = data_valid_o ? head.f_err : 1'b0;
   assign overflow_o   = ovf_q;
   assign fifo_count_o = fcnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: four framings side by side, a queue-level FIFO model checked every
// cycle, plus literal expectations on the directed vectors.
module tb_uart_rx_fifo;
   localparam int CPB [4] = '{40, 40, 40, 347};
   localparam int DB  [4] = '{8, 8, 8, 7};
   localparam int PM  [4] = '{0, 2, 0, 1};
   localparam int SB  [4] = '{1, 1, 1, 2};
   localparam int DEP [4] = '{16, 16, 4, 16};

   logic       clk, rst_n;
   logic [3:0] rx, ack, clr;
   logic [7:0] dout [4];
   logic [3:0] dv, pe, fe, ov;
   logic [4:0] c0, c1, c3;
   logic [2:0] c2;

   uart_rx_fifo #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
      .clk_i(clk), .rst_n_i(rst_n), .rx_i(rx[0]), .data_ack_i(ack[0]), .err_clr_i(clr[0]),
      .data_o(dout[0]), .data_valid_o(dv[0]), .parity_err_o(pe[0]), .frame_err_o(fe[0]),
      .overflow_o(ov[0]), .fifo_count_o(c0));
   uart_rx_fifo #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
      .clk_i(clk), .rst_n_i(rst_n), .rx_i(rx[1]), .data_ack_i(ack[1]), .err_clr_i(clr[1]),
      .data_o(dout[1]), .data_valid_o(dv[1]), .parity_err_o(pe[1]), .frame_err_o(fe[1]),
      .overflow_o(ov[1]), .fifo_count_o(c1));
   uart_rx_fifo #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
      .clk_i(clk), .rst_n_i(rst_n), .rx_i(rx[2]), .data_ack_i(ack[2]), .err_clr_i(clr[2]),
      .data_o(dout[2]), .data_valid_o(dv[2]), .parity_err_o(pe[2]), .frame_err_o(fe[2]),
      .overflow_o(ov[2]), .fifo_count_o(c2));
   uart_rx_fifo #(.BAUD_RATE(115_200), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2),
                  .FIFO_DEPTH(16)) u3 (
      .clk_i(clk), .rst_n_i(rst_n), .rx_i(rx[3]), .data_ack_i(ack[3]), .err_clr_i(clr[3]),
      .data_o(dout[3]), .data_valid_o(dv[3]), .parity_err_o(pe[3]), .frame_err_o(fe[3]),
      .overflow_o(ov[3]), .fifo_count_o(c3));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_pass = 0;
   int n_tot  = 0;

   function automatic void chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d", nm, act, exp);
   endfunction

   // model: expected entry pushed at the last stop-bit centre, as an absolute cycle number
   typedef struct {
      int         inst;
      int         e;
      logic [9:0] ent;
   } pend_t;
   pend_t pend [$];

   int         cyc   = 0;
   logic [3:0] ack_s = '0, clr_s = '0;
   logic       rst_s = 1'b0;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      ack_s <= ack;
      clr_s <= clr;
      rst_s <= rst_n;
   end

   logic [9:0] mmem [4][16];
   int         mhead [4];
   int         mcnt  [4];
   logic       mov   [4];

   always @(negedge clk) begin
      logic       push, drop;
      logic [9:0] ent, hd;
      int         dc [4];
      if (cyc >= 1) begin
         dc[0] = int'(c0); dc[1] = int'(c1); dc[2] = int'(c2); dc[3] = int'(c3);
         if (!rst_s) pend.delete();
         for (int i = 0; i < 4; i++) begin
            if (!rst_s) begin
               mhead[i] = 0; mcnt[i] = 0; mov[i] = 1'b0;
            end else begin
               if (ack_s[i] && mcnt[i] > 0) begin
                  mhead[i] = (mhead[i] + 1) % DEP[i];
                  mcnt[i]--;
               end
               push = 1'b0; drop = 1'b0; ent = '0;
               for (int k = pend.size() - 1; k >= 0; k--)
                  if (pend[k].inst == i && pend[k].e == cyc) begin
                     push = 1'b1; ent = pend[k].ent; pend.delete(k);
                  end
               if (push) begin
                  if (mcnt[i] == DEP[i]) drop = 1'b1;
                  else begin
                     mmem[i][(mhead[i] + mcnt[i]) % DEP[i]] = ent;
                     mcnt[i]++;
                  end
               end
               if (drop) mov[i] = 1'b1;
               else if (clr_s[i]) mov[i] = 1'b0;
            end
            chk($sformatf("u%0d valid @%0d", i, cyc), int'(dv[i]), int'(mcnt[i] > 0));
            chk($sformatf("u%0d count @%0d", i, cyc), dc[i], mcnt[i]);
            chk($sformatf("u%0d overflow @%0d", i, cyc), int'(ov[i]), int'(mov[i]));
            if (mcnt[i] > 0) begin
               hd = mmem[i][mhead[i]];
               chk($sformatf("u%0d data @%0d", i, cyc), int'(dout[i]), int'(hd[7:0]));
               chk($sformatf("u%0d ferr @%0d", i, cyc), int'(fe[i]), int'(hd[8]));
               chk($sformatf("u%0d perr @%0d", i, cyc), int'(pe[i]), int'(hd[9]));
            end
         end
      end
   end

   task automatic send(input int i, input logic [7:0] d, input bit pinv = 1'b0,
                       input bit stop_low = 1'b0, input int glitch_bit = -1,
                       input int hold_low = 0, input int abort_bits = 0);
      int          c, n, k, nb;
      logic [7:0]  m;
      logic [15:0] fr;
      pend_t       p;
      c  = CPB[i];
      m  = d & 8'((1 << DB[i]) - 1);
      n  = 0;
      fr = '0;
      fr[n] = 1'b0; n++;
      for (int b = 0; b < DB[i]; b++) begin fr[n] = m[b]; n++; end
      if (PM[i] != 0) begin
         fr[n] = ((PM[i] == 1) ? ~(^m) : (^m)) ^ pinv;
         n++;
      end
      for (int s = 0; s < SB[i]; s++) begin fr[n] = (s == 0 && stop_low) ? 1'b0 : 1'b1; n++; end
      @(negedge clk);
      k = cyc;
      if (abort_bits == 0) begin
         p.inst = i;
         p.e    = k + 3 + c / 2 + (n - 1) * c;
         p.ent  = {pinv && (PM[i] != 0), stop_low, m};
         pend.push_back(p);
      end
      nb = (abort_bits > 0) ? abort_bits : n;
      for (int b = 0; b < nb; b++)
         for (int t = 0; t < c; t++) begin
            rx[i] = (b == glitch_bit + 1 && (t == c / 2 - 3 || t == c / 2 - 2)) ? 1'b0 : fr[b];
            @(negedge clk);
         end
      for (int t = 0; t < hold_low * c; t++) begin
         rx[i] = 1'b0;
         @(negedge clk);
      end
      rx[i] = 1'b1;
   endtask

   task automatic pop(input int i, input int exp_d, input int exp_pe, input int exp_fe);
      @(negedge clk);
      chk($sformatf("u%0d head data", i), int'(dout[i]), exp_d);
      chk($sformatf("u%0d head perr", i), int'(pe[i]), exp_pe);
      chk($sformatf("u%0d head ferr", i), int'(fe[i]), exp_fe);
      ack[i] = 1'b1;
      @(negedge clk);
      ack[i] = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int t = 0; t < n; t++) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; rx = '1; ack = '0; clr = '0;
      idle(3);
      chk("reset valid", int'(dv), 0);
      chk("reset count u0", int'(c0), 0);
      chk("reset overflow", int'(ov), 0);
      rst_n = 1'b1;
      idle(10);

      // 8N1 back to back
      send(0, 8'h55); send(0, 8'hA3); send(0, 8'h00);
      idle(5);
      chk("8N1 count", int'(c0), 3);
      pop(0, 8'h55, 0, 0); pop(0, 8'hA3, 0, 0); pop(0, 8'h00, 0, 0);
      chk("8N1 drained", int'(dv[0]), 0);

      // 8E1 good then inverted parity
      send(1, 8'hA3); send(1, 8'hA3, 1'b1);
      idle(5);
      chk("8E1 count", int'(c1), 2);
      pop(1, 8'hA3, 0, 0); pop(1, 8'hA3, 1, 0);

      // idle glitch, then voted-out glitch inside bit 3
      @(negedge clk); rx[0] = 1'b0;
      @(negedge clk); rx[0] = 1'b1;
      idle(200);
      chk("glitch no entry", int'(c0), 0);
      send(0, 8'h0F, 1'b0, 1'b0, 3);
      idle(5);
      chk("glitch bit count", int'(c0), 1);
      pop(0, 8'h0F, 0, 0);

      // stop bit low, then line held low (break)
      send(0, 8'h81, 1'b0, 1'b1, -1, 20);
      idle(200);
      chk("break count", int'(c0), 1);
      pop(0, 8'h81, 0, 1);
      chk("break drained", int'(c0), 0);

      // overflow on depth-4 FIFO
      send(2, 8'h11); send(2, 8'h22); send(2, 8'h33); send(2, 8'h44); send(2, 8'h55);
      idle(5);
      chk("ovf count", int'(c2), 4);
      chk("ovf flag", int'(ov[2]), 1);
      @(negedge clk); clr[2] = 1'b1;
      @(negedge clk); clr[2] = 1'b0;
      chk("ovf cleared", int'(ov[2]), 0);
      pop(2, 8'h11, 0, 0); pop(2, 8'h22, 0, 0); pop(2, 8'h33, 0, 0); pop(2, 8'h44, 0, 0);
      chk("ovf drained", int'(c2), 0);

      // 7O2 at 115200: one frame, reset mid-byte, then a clean frame
      send(3, 8'h15);
      idle(5);
      chk("7O2 first count", int'(c3), 1);
      send(3, 8'h3C, 1'b0, 1'b0, -1, 0, 4);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst mid valid", int'(dv[3]), 0);
      chk("rst mid count", int'(c3), 0);
      idle(2000);
      chk("rst no junk", int'(c3), 0);
      send(3, 8'h3C);
      idle(5);
      chk("7O2 count", int'(c3), 1);
      pop(3, 8'h3C, 0, 0);
      idle(5);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
